// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: credit-limited request issue, pc-tag tracking, in-order entry buffer
module if_fetch_unit #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_ready,
   input  logic            flush,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            if_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   // pc-tag FIFO: PCs of requests that are still waiting for memory
   logic [XLEN-1:0] tag_q       [DEPTH];
   logic [XLEN-1:0] tag_d       [DEPTH];
   logic [PW-1:0]   tag_wr_q, tag_wr_d;
   logic [PW-1:0]   tag_rd_q, tag_rd_d;

   // entry FIFO: {pc, instr} pairs waiting for decode
   logic [XLEN-1:0] ent_pc_q    [DEPTH];
   logic [XLEN-1:0] ent_pc_d    [DEPTH];
   logic [XLEN-1:0] ent_instr_q [DEPTH];
   logic [XLEN-1:0] ent_instr_d [DEPTH];
   logic [PW-1:0]   ent_wr_q, ent_wr_d;
   logic [PW-1:0]   ent_rd_q, ent_rd_d;

   logic [CW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   drop_q, drop_d;

   // run_q holds off requests until the first clock after reset release
   logic            run_q, run_d;

   logic            pop;
   logic [CW:0]     credit_used;
   logic            rsp_take;
   logic            rsp_keep;

   // Handshake decode: credit counts in-flight requests plus buffered entries, less the one leaving now
   always_comb begin
      pop            = (occ_q != '0) && if_ready;
      credit_used    = {1'b0, out_q} + {1'b0, occ_q} - (CW + 1)'(pop);
      imem_req_valid = run_q && !flush && (credit_used < DEPTH_C);
      pc_ready       = imem_req_valid && imem_req_ready;
      imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};
      if_valid       = (occ_q != '0);
      if_pc          = ent_pc_q[ent_rd_q];
      if_instr       = ent_instr_q[ent_rd_q];
   end

   // Next-state: tag push on request, tag pop / entry push on kept response, drop accounting on flush
   always_comb begin
      tag_d       = tag_q;
      tag_wr_d    = tag_wr_q;
      tag_rd_d    = tag_rd_q;
      ent_pc_d    = ent_pc_q;
      ent_instr_d = ent_instr_q;
      ent_wr_d    = ent_wr_q;
      ent_rd_d    = ent_rd_q;
      drop_d      = drop_q;
      run_d       = 1'b1;

      // a response with nothing outstanding is spurious and ignored entirely
      rsp_take = imem_rsp_valid && (out_q != '0);
      rsp_keep = rsp_take && (drop_q == '0) && !flush;

      if (pc_ready) begin
         tag_d[tag_wr_q] = pc_in;
         tag_wr_d        = tag_wr_q + PW'(1);
      end

      if (rsp_keep) begin
         ent_pc_d[ent_wr_q]    = tag_q[tag_rd_q];
         ent_instr_d[ent_wr_q] = imem_rsp_data;
         ent_wr_d              = ent_wr_q + PW'(1);
         tag_rd_d              = tag_rd_q + PW'(1);
      end

      if (pop) begin
         ent_rd_d = ent_rd_q + PW'(1);
      end

      if (rsp_take && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      occ_d = occ_q + CW'(rsp_keep) - CW'(pop);
      out_d = out_q + CW'(pc_ready) - CW'(rsp_take);

      // every request still outstanding after this cycle belongs to the discarded path
      if (flush) begin
         tag_wr_d = '0;
         tag_rd_d = '0;
         ent_wr_d = '0;
         ent_rd_d = '0;
         occ_d    = '0;
         drop_d   = out_d;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]       <= '0;
            ent_pc_q[i]    <= '0;
            ent_instr_q[i] <= '0;
         end
         tag_wr_q <= '0;
         tag_rd_q <= '0;
         ent_wr_q <= '0;
         ent_rd_q <= '0;
         occ_q    <= '0;
         out_q    <= '0;
         drop_q   <= '0;
         run_q    <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         ent_pc_q    <= ent_pc_d;
         ent_instr_q <= ent_instr_d;
         tag_wr_q    <= tag_wr_d;
         tag_rd_q    <= tag_rd_d;
         ent_wr_q    <= ent_wr_d;
         ent_rd_q    <= ent_rd_d;
         occ_q       <= occ_d;
         out_q       <= out_d;
         drop_q      <= drop_d;
         run_q       <= run_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clock;
   logic        reset_n;
   logic [31:0] pc_in;
   logic        pc_ready;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend_q[$];
   int    cyc;
   int    lat;
   int    hs_count;
   int    n_assert;
   int    n_fail;
   bit    auto_pc;
   bit    inject;

   if_fetch_unit #(.XLEN(32), .DEPTH(4)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .pc_in          (pc_in),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // instruction memory contents
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h1111_1111;
         32'h0000_0004: return 32'h1010_1010;
         32'h0000_0008: return 32'h1000_1000;
         32'h0000_000C: return 32'h0000_0013;
         default:       return 32'hA000_0000 | a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: drive memory response, record handshake, advance PC register
   task automatic cycle();
      logic        hs;
      logic [31:0] haddr;
      pend_t       p;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else if (inject) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hBAD0_BAD0;
         inject         = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      hs    = pc_ready;
      haddr = imem_req_addr;
      @(posedge clock);
      if (hs === 1'b1) begin
         p.addr = haddr;
         p.due  = cyc + lat;
         pend_q.push_back(p);
         hs_count++;
      end
      cyc++;
      @(negedge clock);
      if (hs === 1'b1 && auto_pc) pc_in = pc_in + 32'd4;
      #1;
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; lat = 1; hs_count = 0;
      auto_pc = 1'b0; inject = 1'b0;
      reset_n = 1'b0; flush = 1'b0; pc_in = 32'h0000_1111;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      if_ready = 1'b1;

      // reset held
      cycle(); cycle();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_pc_ready",  32'(pc_ready),       32'd0);
      chk("rst_if_valid",  32'(if_valid),       32'd0);
      chk("rst_if_pc",     if_pc,               32'h0);
      chk("rst_if_instr",  if_instr,            32'h0);

      // release, then stream 0x0..0xC at latency 1
      imem_req_ready = 1'b0; pc_in = 32'h0; auto_pc = 1'b1;
      reset_n = 1'b1;
      cycle();
      imem_req_ready = 1'b1;
      #1;
      chk("s_req_valid", 32'(imem_req_valid), 32'd1);
      chk("s_pc_ready",  32'(pc_ready),       32'd1);
      chk("s_req_addr",  imem_req_addr,       32'h0);
      cycle();
      chk("s_valid_lat1", 32'(if_valid), 32'd0);
      cycle();
      chk("s_valid_lat2", 32'(if_valid), 32'd1);
      chk("s_pc0",    if_pc,    32'h0000_0000);
      chk("s_instr0", if_instr, 32'h1111_1111);
      cycle();
      chk("s_pc1",    if_pc,    32'h0000_0004);
      chk("s_instr1", if_instr, 32'h1010_1010);
      cycle();
      chk("s_pc2",    if_pc,    32'h0000_0008);
      chk("s_instr2", if_instr, 32'h1000_1000);
      cycle();
      chk("s_pc3",    if_pc,    32'h0000_000C);
      chk("s_instr3", if_instr, 32'h0000_0013);
      imem_req_ready = 1'b0;
      repeat (5) cycle();
      chk("s_drained", 32'(if_valid), 32'd0);

      // reset asserted mid-stream
      pc_in = 32'h0000_0040; imem_req_ready = 1'b1;
      cycle(); cycle();
      chk("m_pre_valid", 32'(if_valid), 32'd1);
      chk("m_pre_pc",    if_pc,         32'h0000_0040);
      chk("m_pre_instr", if_instr,      32'hA000_0040);
      reset_n = 1'b0;
      pend_q.delete();
      #1;
      chk("m_req_valid", 32'(imem_req_valid), 32'd0);
      chk("m_pc_ready",  32'(pc_ready),       32'd0);
      chk("m_if_valid",  32'(if_valid),       32'd0);
      chk("m_if_pc",     if_pc,               32'h0);
      chk("m_if_instr",  if_instr,            32'h0);
      cycle();
      imem_req_ready = 1'b0;
      reset_n = 1'b1;
      cycle();
      chk("m_post_valid0", 32'(if_valid), 32'd0);
      cycle();
      chk("m_post_valid1", 32'(if_valid), 32'd0);

      // backpressure from decode: exactly DEPTH requests
      pc_in = 32'h0; if_ready = 1'b0; imem_req_ready = 1'b1; hs_count = 0;
      repeat (10) cycle();
      chk("b_handshakes", 32'(hs_count),      32'd4);
      chk("b_req_valid",  32'(imem_req_valid), 32'd0);
      chk("b_if_valid",   32'(if_valid),       32'd1);
      chk("b_if_pc",      if_pc,               32'h0);
      chk("b_if_instr",   if_instr,            32'h1111_1111);
      if_ready = 1'b1;
      #1;
      chk("b_resume", 32'(imem_req_valid), 32'd1);
      cycle();
      chk("b_pc1", if_pc, 32'h0000_0004);
      cycle();
      chk("b_pc2", if_pc, 32'h0000_0008);
      cycle();
      chk("b_pc3", if_pc, 32'h0000_000C);
      cycle();
      chk("b_pc4",    if_pc,    32'h0000_0010);
      chk("b_instr4", if_instr, 32'hA000_0010);
      imem_req_ready = 1'b0;
      repeat (6) cycle();
      chk("b_drained", 32'(if_valid), 32'd0);

      // flush with two requests in flight at latency 3
      lat = 3; pc_in = 32'h0000_0100; imem_req_ready = 1'b1;
      cycle(); cycle();
      flush = 1'b1; pc_in = 32'h0000_2000;
      #1;
      chk("f_req_valid", 32'(imem_req_valid), 32'd0);
      chk("f_pc_ready",  32'(pc_ready),       32'd0);
      cycle();
      flush = 1'b0;
      chk("f_if_valid", 32'(if_valid), 32'd0);
      cycle();
      chk("f_drop0", 32'(if_valid), 32'd0);
      cycle();
      chk("f_drop1", 32'(if_valid), 32'd0);
      cycle();
      chk("f_wait", 32'(if_valid), 32'd0);
      cycle();
      chk("f_first_valid", 32'(if_valid), 32'd1);
      chk("f_first_pc",    if_pc,         32'h0000_2000);
      chk("f_first_instr", if_instr,      32'hA000_2000);
      imem_req_ready = 1'b0;
      repeat (10) cycle();
      chk("f_drained", 32'(if_valid), 32'd0);

      // memory stalls the request
      lat = 1; pc_in = 32'h0000_1000; imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("q_req_valid", 32'(imem_req_valid), 32'd1);
         chk("q_pc_ready",  32'(pc_ready),       32'd0);
         chk("q_req_addr",  imem_req_addr,       32'h0000_1000);
      end
      chk("q_no_entry", 32'(if_valid), 32'd0);

      // unaligned PC and unsolicited response
      auto_pc = 1'b0; pc_in = 32'h0000_1111;
      #1;
      chk("u_req_addr", imem_req_addr, 32'h0000_1110);
      inject = 1'b1;
      cycle(); cycle();
      chk("u_spurious", 32'(if_valid), 32'd0);
      imem_req_ready = 1'b1;
      #1;
      chk("u_pc_ready", 32'(pc_ready), 32'd1);
      cycle();
      imem_req_ready = 1'b0;
      cycle();
      chk("u_valid", 32'(if_valid), 32'd1);
      chk("u_pc",    if_pc,         32'h0000_1111);
      chk("u_instr", if_instr,      32'hA000_1110);
      cycle();
      chk("u_empty", 32'(if_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
